// File: rtl/asynch_receiver.sv
// asynch_receiver
// Asynchronous serial receiver for an idle-high line carrying frames of one
// start bit (0), D data bits sent LSB-first, and one stop bit (1). The line is
// oversampled at 16x the baud rate and every bit is sampled at its midpoint.
// Each good frame is presented on data together with a one-cycle rdy strobe.
// A frame whose stop bit is low raises a one-cycle ferr strobe and leaves data
// untouched.
//
// Parameters
//   CLKFREQ  system clock frequency in Hz
//   BAUD     line bit rate in bits/s; CLKFREQ/(BAUD*16) must be at least 1
//   D        data bits per frame
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   rxd        serial input, asynchronous to clk, idle high
//   data       last correctly received word; holds until the next good frame
//   rdy        one-cycle pulse: data was just updated with a new good frame
//   ferr       one-cycle pulse: stop bit was sampled low (framing error)
//   receiving  high from start-edge detection until the receiver is idle again
`timescale 1ps/1ps
module asynch_receiver #(
   parameter int CLKFREQ = 100_000_000,
   parameter int BAUD    = 9600,
   parameter int D       = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rxd,
   output logic [D-1:0] data,
   output logic         rdy,
   output logic         ferr,
   output logic         receiving
);

   localparam int DIV  = CLKFREQ / (BAUD * 16);
   localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDXW = (D > 1) ? $clog2(D) : 1;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(D - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t          state_q, state_d;
   logic            rxdMeta_q, rxdSync_q;
   logic [DIVW-1:0] divCnt_q, divCnt_d;
   logic [3:0]      sampleCnt_q, sampleCnt_d;
   logic [IDXW-1:0] bitIdx_q, bitIdx_d;
   logic [D-1:0]    shift_q, shift_d;
   logic [D-1:0]    data_q, data_d;
   logic            rdy_q, rdy_d;
   logic            ferr_q, ferr_d;
   logic            tick;
   logic            startEdge;
   logic            midStart;
   logic            midBit;

   // Two-flop synchronizer for the asynchronous line. The flops reset to the
   // idle level so that leaving reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rxdMeta_q <= 1'b1;
         rxdSync_q <= 1'b1;
      end else begin
         rxdMeta_q <= rxd;
         rxdSync_q <= rxdMeta_q;
      end
   end

   // The 16x oversampling tick fires on the last count of the divider. The
   // divider restarts at the start edge so that all later samples are
   // phase-aligned to the falling edge of the start bit rather than to an
   // arbitrary free-running phase.
   assign startEdge = (state_q == IDLE) && !rxdSync_q;
   assign tick      = (divCnt_q == DIV_LAST);
   assign midStart  = tick && (sampleCnt_q == 4'd7);
   assign midBit    = tick && (sampleCnt_q == 4'd15);

   always_comb begin
      divCnt_d = divCnt_q + 1'b1;
      if (startEdge || tick) begin
         divCnt_d = '0;
      end
   end

   // Next-state logic. The sample counter simply free-runs on ticks and wraps
   // from 15 to 0, so once it is cleared at mid start bit every following wrap
   // lands exactly on the midpoint of the next bit. The shift register fills
   // from the MSB end, which leaves the LSB-first word correctly ordered after
   // D shifts.
   always_comb begin
      state_d     = state_q;
      sampleCnt_d = tick ? (sampleCnt_q + 4'd1) : sampleCnt_q;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      rdy_d       = 1'b0;
      ferr_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxdSync_q) begin
               state_d     = START;
               sampleCnt_d = 4'd0;
            end
         end
         START: begin
            if (midStart) begin
               if (!rxdSync_q) begin
                  state_d     = DATA;
                  sampleCnt_d = 4'd0;
                  bitIdx_d    = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (midBit) begin
               shift_d = (shift_q >> 1) | (D'(rxdSync_q) << (D - 1));
               if (bitIdx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (midBit) begin
               if (rxdSync_q) begin
                  data_d  = shift_q;
                  rdy_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            if (rxdSync_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, including the registered strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         divCnt_q    <= '0;
         sampleCnt_q <= 4'd0;
         bitIdx_q    <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         rdy_q       <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         divCnt_q    <= divCnt_d;
         sampleCnt_q <= sampleCnt_d;
         bitIdx_q    <= bitIdx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         rdy_q       <= rdy_d;
         ferr_q      <= ferr_d;
      end
   end

   assign data      = data_q;
   assign rdy       = rdy_q;
   assign ferr      = ferr_q;
   assign receiving = (state_q != IDLE);

endmodule

// File: tb/tb_asynch_receiver.sv
// tb_asynch_receiver
// Self-checking bench for asynch_receiver at CLKFREQ=16 MHz, BAUD=500k, which
// gives a divider of 2 and a bit period of 32 clocks (320 ns).
`timescale 1ps/1ps
module tb_asynch_receiver;

   localparam int CLKFREQ  = 16_000_000;
   localparam int BAUD     = 500_000;
   localparam int D        = 8;
   localparam int CLK_HALF = 5000;
   localparam int BIT_PS   = 320000;
   localparam int LAT_LO   = 300;
   localparam int LAT_HI   = 312;

   logic         clk;
   logic         reset;
   logic         rxd;
   logic [D-1:0] data;
   logic         rdy;
   logic         ferr;
   logic         receiving;

   asynch_receiver #(
      .CLKFREQ(CLKFREQ),
      .BAUD(BAUD),
      .D(D)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rxd(rxd),
      .data(data),
      .rdy(rdy),
      .ferr(ferr),
      .receiving(receiving)
   );

   typedef struct {
      logic [7:0] byteVal;
      logic       stopBit;
      int         bitPs;
      int         expRdy;
      int         expFerr;
      logic [7:0] expData;
   } vec_t;

   vec_t vecs[5];

   int assertCount = 0;
   int failCount   = 0;
   int startCycle  = 0;

   int         cycle         = 0;
   int         rdyCount      = 0;
   int         ferrCount     = 0;
   int         bothCount     = 0;
   int         recvCycles    = 0;
   int         lastRdyCycle  = 0;
   int         lastFerrCycle = 0;
   logic [7:0] rdyLog [0:15];

   initial begin
      clk = 1'b0;
      forever #(CLK_HALF) clk = ~clk;
   end

   // Output monitor, sampled on the falling edge away from the active edge.
   always @(negedge clk) begin
      cycle <= cycle + 1;
      if (rdy) begin
         rdyCount            <= rdyCount + 1;
         lastRdyCycle        <= cycle + 1;
         rdyLog[rdyCount[3:0]] <= data;
      end
      if (ferr) begin
         ferrCount     <= ferrCount + 1;
         lastFerrCycle <= cycle + 1;
      end
      if (rdy && ferr) begin
         bothCount <= bothCount + 1;
      end
      if (receiving) begin
         recvCycles <= recvCycles + 1;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      assertCount++;
      if (actual < lo || actual > hi) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   // Serial transmitter model: start bit, 8 data bits LSB-first, stop bit,
   // each lasting bitPs. With align set the start edge is placed just after
   // a falling clock edge and its cycle number is recorded.
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                                input int bitPs, input bit align);
      if (align) begin
         @(negedge clk);
         #1;
         startCycle = cycle;
      end
      rxd = 1'b0;
      #(bitPs);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         #(bitPs);
      end
      rxd = stopBit;
      #(bitPs);
      rxd = 1'b1;
   endtask

   initial begin
      int r0;
      int f0;
      int rc0;
      int lat;
      logic [7:0] b3c;
      logic [7:0] b81;

      vecs[0] = '{8'h55, 1'b1, 329600, 1, 0, 8'h55};
      vecs[1] = '{8'h55, 1'b1, 310400, 1, 0, 8'h55};
      vecs[2] = '{8'hC3, 1'b1, BIT_PS, 1, 0, 8'hC3};
      vecs[3] = '{8'h0F, 1'b0, BIT_PS, 0, 1, 8'hC3};
      vecs[4] = '{8'hA5, 1'b1, BIT_PS, 1, 0, 8'hA5};

      reset = 1'b1;
      rxd   = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("reset data", int'(data), 0);
      checkOutput("reset rdy", int'(rdy), 0);
      checkOutput("reset ferr", int'(ferr), 0);
      checkOutput("reset receiving", int'(receiving), 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Table-driven single frames, including +/-3% bit periods and a bad stop bit.
      for (int i = 0; i < 5; i++) begin
         r0 = rdyCount;
         f0 = ferrCount;
         applyStimulus(vecs[i].byteVal, vecs[i].stopBit, vecs[i].bitPs, 1'b1);
         #(2 * BIT_PS);
         checkOutput($sformatf("vec%0d rdy count", i), rdyCount - r0, vecs[i].expRdy);
         checkOutput($sformatf("vec%0d ferr count", i), ferrCount - f0, vecs[i].expFerr);
         checkOutput($sformatf("vec%0d data", i), int'(data), int'(vecs[i].expData));
         checkOutput($sformatf("vec%0d receiving", i), int'(receiving), 0);
         lat = ((vecs[i].expRdy != 0) ? lastRdyCycle : lastFerrCycle) - startCycle;
         checkRange($sformatf("vec%0d latency", i), lat, LAT_LO, LAT_HI);
      end

      // Short low glitch must be rejected at mid start bit.
      @(negedge clk);
      #1;
      r0  = rdyCount;
      f0  = ferrCount;
      rc0 = recvCycles;
      rxd = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      rxd = 1'b1;
      #(2 * BIT_PS);
      checkOutput("glitch rdy count", rdyCount - r0, 0);
      checkOutput("glitch ferr count", ferrCount - f0, 0);
      checkOutput("glitch data", int'(data), 'hA5);
      checkOutput("glitch receiving", int'(receiving), 0);
      checkRange("glitch receiving cycles", recvCycles - rc0, 10, 24);

      // Framing error followed by a long break, then a clean frame.
      b3c = 8'h3C;
      r0  = rdyCount;
      f0  = ferrCount;
      @(negedge clk);
      #1;
      startCycle = cycle;
      rxd = 1'b0;
      #(BIT_PS);
      for (int i = 0; i < 8; i++) begin
         rxd = b3c[i];
         #(BIT_PS);
      end
      rxd = 1'b0;
      #(20 * BIT_PS);
      checkOutput("break ferr count", ferrCount - f0, 1);
      checkOutput("break rdy count", rdyCount - r0, 0);
      checkOutput("break data", int'(data), 'hA5);
      checkOutput("break receiving", int'(receiving), 1);
      checkRange("break ferr latency", lastFerrCycle - startCycle, LAT_LO, LAT_HI);
      rxd = 1'b1;
      #(BIT_PS);
      checkOutput("after break receiving", int'(receiving), 0);
      applyStimulus(8'h5A, 1'b1, BIT_PS, 1'b1);
      #(2 * BIT_PS);
      checkOutput("post-break rdy count", rdyCount - r0, 1);
      checkOutput("post-break data", int'(data), 'h5A);
      checkOutput("post-break ferr count", ferrCount - f0, 1);

      // Back-to-back frames with no idle time between stop and next start.
      r0 = rdyCount;
      f0 = ferrCount;
      applyStimulus(8'h00, 1'b1, BIT_PS, 1'b1);
      applyStimulus(8'hFF, 1'b1, BIT_PS, 1'b0);
      #(2 * BIT_PS);
      checkOutput("b2b rdy count", rdyCount - r0, 2);
      checkOutput("b2b first data", int'(rdyLog[r0 % 16]), 'h00);
      checkOutput("b2b second data", int'(rdyLog[(r0 + 1) % 16]), 'hFF);
      checkOutput("b2b ferr count", ferrCount - f0, 0);

      // Reset one clock after the 4th data bit sample of 0x81; the
      // transmitter side is reset too, so the line returns to idle.
      b81 = 8'h81;
      r0  = rdyCount;
      f0  = ferrCount;
      @(negedge clk);
      #1;
      startCycle = cycle;
      for (int c = 0; c < 147; c++) begin
         rxd = (c < 32) ? 1'b0 : b81[(c / 32) - 1];
         @(negedge clk);
         #1;
      end
      checkOutput("pre-reset receiving", int'(receiving), 1);
      reset = 1'b1;
      rxd   = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("midframe reset data", int'(data), 0);
      checkOutput("midframe reset rdy", int'(rdy), 0);
      checkOutput("midframe reset ferr", int'(ferr), 0);
      checkOutput("midframe reset receiving", int'(receiving), 0);
      reset = 1'b0;
      #(2 * BIT_PS);
      checkOutput("discarded rdy count", rdyCount - r0, 0);
      checkOutput("discarded ferr count", ferrCount - f0, 0);
      applyStimulus(8'h81, 1'b1, BIT_PS, 1'b1);
      #(2 * BIT_PS);
      checkOutput("after reset rdy count", rdyCount - r0, 1);
      checkOutput("after reset data", int'(data), 'h81);
      checkOutput("after reset ferr count", ferrCount - f0, 0);
      checkRange("after reset latency", lastRdyCycle - startCycle, LAT_LO, LAT_HI);

      checkOutput("rdy and ferr together", bothCount, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
